mdu_seq: RTL and testbench

//   Sequential multiply/divide unit with architectural HI/LO registers. It sits

---
 rtl/mdu_seq_pkg.sv | 25 ++
 rtl/mdu_seq_if.sv | 18 +
 rtl/mdu_divstep.sv | 27 ++
 rtl/mdu_seq.sv | 134 +++++++++++++
 tb/tb_mdu_seq.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared op encodes and helpers for the sequential multiply/divide unit.
package mdu_seq_pkg;

  typedef logic [2:0] mdu_op_t;

  localparam mdu_op_t MDU_MULT  = 3'd0;
  localparam mdu_op_t MDU_MULTU = 3'd1;
  localparam mdu_op_t MDU_DIV   = 3'd2;
  localparam mdu_op_t MDU_DIVU  = 3'd3;
  localparam mdu_op_t MDU_MTHI  = 3'd4;
  localparam mdu_op_t MDU_MTLO  = 3'd5;

  function automatic logic is_mul_op(mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(mdu_op_t op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the control unit and the multiply/divide unit.
interface mdu_seq_if
  import mdu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  mdu_op_t          mdu_op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, mdu_op, A, B, input busy, done, hi, lo);
  modport slave  (input start, mdu_op, A, B, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_divstep.sv
// One restoring-division step on unsigned magnitudes.
module mdu_divstep #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit into the remainder, subtract if it fits.
  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = shifted - {1'b0, divisor_i};
    // rem_i < divisor_i, so a set top bit of trial means the subtraction borrowed
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mdu_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Operands are held as magnitudes; signs are reapplied in the FIX cycle.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic       clk,
  input  logic       rstn,
  mdu_seq_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  // MUL: {partial product high, multiplier/product low}; DIV: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div_q, qneg_q, rneg_q, dz_q, done_q;

  logic               a_neg, b_neg, last_iter;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_nx, quo_nx, div_hi, div_lo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx, prod;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .quo_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opb_q),
    .rem_o     (rem_nx),
    .quo_o     (quo_nx)
  );

  // Operand magnitudes at issue, one shift-add step, and sign fix-up of results.
  always_comb begin
    a_neg     = is_signed_op(bus.mdu_op) & bus.A[WIDTH-1];
    b_neg     = is_signed_op(bus.mdu_op) & bus.B[WIDTH-1];
    a_mag     = a_neg ? -bus.A : bus.A;
    b_mag     = b_neg ? -bus.B : bus.B;
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_nx    = {mul_sum, acc_q[WIDTH-1:1]};
    prod      = qneg_q ? -acc_q : acc_q;
    // Divide by zero leaves quotient all-ones and remainder = |A|, so hi returns to raw A
    div_lo    = dz_q ? '1 : (qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    div_hi    = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && is_mul_op(bus.mdu_op)) state_d = MUL;
        else if (bus.start && is_div_op(bus.mdu_op)) state_d = DIV;
      end
      MUL, DIV: if (last_iter) state_d = FIX;
      FIX:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q    <= '0;
            is_div_q <= is_div_op(bus.mdu_op);
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            dz_q     <= (bus.B == '0);
            if (is_mul_op(bus.mdu_op)) begin
              acc_q <= {{WIDTH{1'b0}}, b_mag};
              opb_q <= a_mag;
            end else if (is_div_op(bus.mdu_op)) begin
              acc_q <= {{WIDTH{1'b0}}, a_mag};
              opb_q <= b_mag;
            end else if (bus.mdu_op == MDU_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.mdu_op == MDU_MTLO) begin
              lo_q <= bus.A;
            end
          end
        end
        MUL: begin
          acc_q <= mul_nx;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DIV: begin
          acc_q <= {rem_nx, quo_nx};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: begin
          done_q <= 1'b1;
          if (is_div_q) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: issue tasks push expected {hi,lo}; a monitor
// pops on every done pulse.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

  localparam int unsigned W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mdu_seq_if #(.WIDTH(W)) bus ();

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got hi=%h lo=%h, expected no done", bus.hi, bus.lo);
        end else begin
          exp = sb_q.pop_front();
          check("result", {bus.hi, bus.lo}, exp);
        end
      end
    end
  end

  // Issue a mult/div and check busy/done timing and that hi/lo hold until FIX.
  task automatic run_op(input mdu_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input bit inject);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = b;
    sb_q.push_back({eh, el});
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.A     = $urandom;
      bus.B     = $urandom;
      if (inject && k == 5) begin
        bus.start  = 1'b1;
        bus.mdu_op = MDU_MTHI;
        bus.A      = 32'h0000_1234;
      end
      check("busy_high", {63'd0, bus.busy}, 64'd1);
      check("done_early", {63'd0, bus.done}, 64'd0);
      check("hilo_hold", {bus.hi, bus.lo}, {m_hi, m_lo});
    end
    @(negedge clk);
    check("busy_fall", {63'd0, bus.busy}, 64'd0);
    check("done_pulse", {63'd0, bus.done}, 64'd1);
    m_hi = eh;
    m_lo = el;
    @(negedge clk);
    check("done_once", {63'd0, bus.done}, 64'd0);
  endtask

  // Single-edge ops in IDLE (MTHI/MTLO or undefined encodes).
  task automatic idle_op(input mdu_op_t op, input logic [W-1:0] a);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = op;
    bus.A      = a;
    bus.B      = 32'h0000_0003;
    if (op == MDU_MTHI) m_hi = a;
    if (op == MDU_MTLO) m_lo = a;
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_busy", {63'd0, bus.busy}, 64'd0);
    check("idle_done", {63'd0, bus.done}, 64'd0);
    check("idle_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
    @(negedge clk);
    check("idle_done2", {63'd0, bus.done}, 64'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.mdu_op = MDU_MULT;
    bus.A      = '0;
    bus.B      = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rstn = 1'b1;

    run_op(MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(MDU_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
    run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
    run_op(MDU_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b0);
    run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op(MDU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);

    // MTHI issued mid-MULT must be dropped; hi keeps its old value until FIX.
    run_op(MDU_MULT,  32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 1'b1);
    idle_op(MDU_MTLO, 32'h0000_CAFE);
    idle_op(MDU_MTHI, 32'h0000_BEEF);
    idle_op(3'b111,   32'hDEAD_0000);

    // Reset ten cycles into a DIV aborts it without a done.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mdu_op = MDU_DIV;
    bus.A      = 32'd100;
    bus.B      = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rstn = 1'b1;

    run_op(MDU_MULTU, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
